// File: rtl/fxp_pkg.sv
// Shared constants and helpers for the fixed-point multiply scheduler.
// Holds the default geometry (requesters, word length, fraction bits), the
// id-width helper and the saturation limits. Both limits are returned in a
// MAX_W_LEN-bit container, and the user slices off the low W_LEN bits.
package fxp_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W_LEN   = 16;
  localparam int DEF_W_FRACT = 14;
  localparam int MAX_W_LEN   = 32;

  // Width of a requester index; never below one bit.
  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Largest positive value of a w_len-bit two's-complement word: 2^(w-1)-1.
  function automatic logic [MAX_W_LEN-1:0] sat_max(input int w_len);
    return MAX_W_LEN'((64'd1 << (w_len - 1)) - 64'd1);
  endfunction

  // Most negative value of a w_len-bit two's-complement word: -2^(w-1).
  function automatic logic [MAX_W_LEN-1:0] sat_min(input int w_len);
    return MAX_W_LEN'(64'd1 << (w_len - 1));
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin arbiter core (purely combinational).
//   req       : request vector, one bit per requester
//   ptr       : index holding highest priority this cycle
//   grant     : one-hot grant, or zero when nothing is requested
//   grant_idx : binary index of the granted requester
//   grant_any : some requester is granted
// The search starts at ptr and wraps around, so the first active request
// found at or after ptr wins.
module rr_grant
  import fxp_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      int idx;
      idx = (int'(ptr) + off) % N_REQ;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fxp_mul_sched.sv
// Round-robin scheduled fixed-point multiplier.
// Up to N_REQ requesters share one signed Q(W_LEN-W_FRACT).W_FRACT
// multiplier. The multiplier has a two-stage pipeline: an issue register holds
// the operands and id, and a result register holds the product, flags and id.
//   clk, reset                       : rising-edge clock, async active-high reset
//   req_valid/req_ready/req_a/req_b  : per-requester handshake and operands
//   rsp_valid/rsp_ready              : result handshake
//   rsp_id                           : index of the originating requester
//   rsp_product                      : floored product, saturated when SAT=1
//   rsp_overflow/rsp_underflow       : true product outside the representable range
module fxp_mul_sched
  import fxp_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W_LEN   = DEF_W_LEN,
  parameter int W_FRACT = DEF_W_FRACT,
  parameter int SAT     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W_LEN-1:0]     req_a,
  input  logic [N_REQ*W_LEN-1:0]     req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [id_width(N_REQ)-1:0] rsp_id,
  output logic [W_LEN-1:0]           rsp_product,
  output logic                       rsp_overflow,
  output logic                       rsp_underflow
);

  localparam int ID_W = id_width(N_REQ);
  localparam int P_W  = 2 * W_LEN;
  localparam logic [MAX_W_LEN-1:0] SAT_MAX_FULL = sat_max(W_LEN);
  localparam logic [MAX_W_LEN-1:0] SAT_MIN_FULL = sat_min(W_LEN);
  localparam logic [W_LEN-1:0]     SAT_MAX      = SAT_MAX_FULL[W_LEN-1:0];
  localparam logic [W_LEN-1:0]     SAT_MIN      = SAT_MIN_FULL[W_LEN-1:0];

  typedef struct packed {
    logic [W_LEN-1:0] product;
    logic             overflow;
    logic             underflow;
  } mul_res_t;

  // The full-width product is taken modulo 2^P_W. Its value equals the signed
  // product because both operands are sign-extended first. The top bits from
  // W_LEN+W_FRACT-1 upward must all match the sign, or the scaled result does
  // not fit.
  function automatic mul_res_t fxp_mul(input logic [W_LEN-1:0] a, input logic [W_LEN-1:0] b);
    logic [P_W-1:0]                 p;
    logic [P_W-W_LEN-W_FRACT:0]     top;
    logic                           fits;
    mul_res_t                       r;
    p   = {{W_LEN{a[W_LEN-1]}}, a} * {{W_LEN{b[W_LEN-1]}}, b};
    top = p[P_W-1:W_LEN+W_FRACT-1];
    fits = (&top) | ~(|top);
    r.overflow  = ~fits & ~p[P_W-1];
    r.underflow = ~fits &  p[P_W-1];
    r.product   = p[W_LEN+W_FRACT-1:W_FRACT];
    if (SAT != 0 && r.overflow)  r.product = SAT_MAX;
    if (SAT != 0 && r.underflow) r.product = SAT_MIN;
    return r;
  endfunction

  // State
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             iss_valid_q, iss_valid_d;
  logic [W_LEN-1:0] iss_a_q, iss_a_d, iss_b_q, iss_b_d;
  logic [ID_W-1:0]  iss_id_q, iss_id_d;
  logic             res_valid_q, res_valid_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  mul_res_t         res_q, res_d;

  // Arbitration
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic             stall, iss_en, xfer;
  mul_res_t         mul_out;

  rr_grant #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_grant (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    stall   = res_valid_q & ~rsp_ready;
    // The issue slot is free when it is empty, or when it drains into the
    // result stage on this edge.
    iss_en  = ~iss_valid_q | ~stall;
    xfer    = grant_any & iss_en & ~reset;
    req_ready = xfer ? grant : '0;
    mul_out = fxp_mul(iss_a_q, iss_b_q);

    ptr_d       = ptr_q;
    iss_valid_d = iss_valid_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    iss_id_d    = iss_id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_d       = res_q;

    // The pointer advances only on a real transfer, to one past the winner.
    if (xfer) begin
      ptr_d    = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      iss_a_d  = req_a[grant_idx*W_LEN +: W_LEN];
      iss_b_d  = req_b[grant_idx*W_LEN +: W_LEN];
      iss_id_d = grant_idx;
    end
    if (iss_en) iss_valid_d = xfer;

    if (!stall) begin
      res_valid_d = iss_valid_q;
      if (iss_valid_q) begin
        res_d    = mul_out;
        res_id_d = iss_id_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_id_q    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      iss_valid_q <= iss_valid_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_id_q    <= iss_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_q       <= res_d;
    end
  end

  assign rsp_valid     = res_valid_q;
  assign rsp_id        = res_id_q;
  assign rsp_product   = res_q.product;
  assign rsp_overflow  = res_q.overflow;
  assign rsp_underflow = res_q.underflow;

endmodule

// File: tb/tb_fxp_mul_sched.sv
// Directed bench for fxp_mul_sched. It instantiates two copies that share all
// inputs: one saturating (SAT=1) and one wrapping (SAT=0). Inputs change on
// the falling edge, and outputs are sampled on the falling edge.
module tb_fxp_mul_sched;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic           rsp_ready;

  logic [N-1:0] req_ready, req_ready_w;
  logic         rsp_valid, rsp_valid_w;
  logic [1:0]   rsp_id, rsp_id_w;
  logic [W-1:0] rsp_product, rsp_product_w;
  logic         rsp_ov, rsp_un, rsp_ov_w, rsp_un_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fxp_mul_sched #(.N_REQ(N), .W_LEN(W), .W_FRACT(14), .SAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_overflow(rsp_ov), .rsp_underflow(rsp_un)
  );

  fxp_mul_sched #(.N_REQ(N), .W_LEN(W), .W_FRACT(14), .SAT(0)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_w), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid_w), .rsp_ready(rsp_ready), .rsp_id(rsp_id_w),
    .rsp_product(rsp_product_w), .rsp_overflow(rsp_ov_w), .rsp_underflow(rsp_un_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated request from requester i, with its response checked at t+2.
  task automatic single_op(input string tag, input int i,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_p, input logic exp_ov,
                           input logic exp_un, input logic [W-1:0] exp_pw);
    @(negedge clk);
    set_op(i, a, b);
    req_valid = '0; req_valid[i] = 1'b1;
    #1 check({tag, " ready"}, req_ready, 32'(1 << i));
    @(negedge clk);
    req_valid = '0;
    check({tag, " valid_t1"}, rsp_valid, 0);
    @(negedge clk);
    check({tag, " valid_t2"}, rsp_valid, 1);
    check({tag, " id"}, rsp_id, i);
    check({tag, " product"}, rsp_product, exp_p);
    check({tag, " ovf"}, rsp_ov, exp_ov);
    check({tag, " unf"}, rsp_un, exp_un);
    check({tag, " product_wrap"}, rsp_product_w, exp_pw);
    check({tag, " ovf_wrap"}, rsp_ov_w, exp_ov);
    check({tag, " unf_wrap"}, rsp_un_w, exp_un);
  endtask

  initial begin
    reset = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    #12;
    check("reset ready", req_ready, 0);
    check("reset valid", rsp_valid, 0);
    check("reset product", rsp_product, 0);
    check("reset id", rsp_id, 0);
    check("reset flags", {rsp_ov, rsp_un}, 0);
    @(negedge clk);
    req_valid = '0;
    reset = 1'b0;

    // Arithmetic vectors: product, flags, saturated and wrapped results.
    single_op("one_x_one", 0, 16'h4000, 16'h4000, 16'h4000, 0, 0, 16'h4000);
    single_op("max_sq",    1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 0, 16'hFFFC);
    single_op("max_min",   2, 16'h7FFF, 16'h8000, 16'h8000, 0, 1, 16'h0002);
    single_op("neg_half",  3, 16'hC000, 16'h4000, 16'hC000, 0, 0, 16'hC000);
    single_op("min_sq",    0, 16'h8000, 16'h8000, 16'h7FFF, 1, 0, 16'h0000);
    single_op("floor_m1",  1, 16'hFFFF, 16'h0001, 16'hFFFF, 0, 0, 16'hFFFF);

    // Round-robin with all four requesters valid, one transfer per cycle.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 16'h4000, 16'((i + 1) * 16'h1000));
    req_valid = 4'hF;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      #1 check($sformatf("rr ready %0d", j), req_ready, 32'(1 << (j % 4)));
      if (j >= 2) begin
        check($sformatf("rr valid %0d", j), rsp_valid, 1);
        check($sformatf("rr id %0d", j), rsp_id, (j - 2) % 4);
        check($sformatf("rr product %0d", j), rsp_product, ((j - 2) % 4 + 1) * 32'h1000);
      end
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    // Backpressure: two operations in flight, outputs held, order preserved.
    do_reset();
    set_op(0, 16'h4000, 16'h2000);
    set_op(1, 16'h2000, 16'h2000);
    set_op(2, 16'hC000, 16'h4000);
    rsp_ready = 1'b0;
    req_valid = 4'b0111;
    #1 check("bp ready0", req_ready, 32'b0001);
    @(negedge clk);
    req_valid = 4'b0110;
    check("bp ready1", req_ready, 32'b0010);
    @(negedge clk);
    req_valid = 4'b0100;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("bp hold valid %0d", j), rsp_valid, 1);
      check($sformatf("bp hold id %0d", j), rsp_id, 0);
      check($sformatf("bp hold product %0d", j), rsp_product, 32'h2000);
      check($sformatf("bp hold ready %0d", j), req_ready, 0);
    end
    rsp_ready = 1'b1;
    #1 check("bp release ready", req_ready, 32'b0100);
    @(negedge clk);
    req_valid = '0;
    check("bp out1 valid", rsp_valid, 1);
    check("bp out1 id", rsp_id, 1);
    check("bp out1 product", rsp_product, 32'h1000);
    @(negedge clk);
    check("bp out2 valid", rsp_valid, 1);
    check("bp out2 id", rsp_id, 2);
    check("bp out2 product", rsp_product, 32'hC000);
    @(negedge clk);
    check("bp drained", rsp_valid, 0);

    // Reset pulsed with two operations in flight.
    do_reset();
    set_op(0, 16'h4000, 16'h4000);
    set_op(1, 16'h4000, 16'h4000);
    req_valid = 4'b0011;
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    check("mid valid before reset", rsp_valid, 1);
    reset = 1'b1;
    req_valid = 4'hF;
    #1 check("mid valid in reset", rsp_valid, 0);
    check("mid ready in reset", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("mid grant after reset", req_ready, 32'b0001);
    req_valid = '0;
    @(negedge clk);
    check("mid no ghost 1", rsp_valid, 0);
    @(negedge clk);
    check("mid no ghost 2", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fxp_mul_sched.md
FXP_MUL_SCHED -- requirements
Module: fxp_mul_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W_LEN, default 16, operand and result word length.
REQ-003 SHALL have parameter W_FRACT, default 14, fractional bits of operands and result.
REQ-004 SHALL have parameter SAT, default 1; 1 = saturate on overflow/underflow, 0 = truncate (wrap).
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester request valid.
REQ-008 SHALL have port req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-009 SHALL have port req_a  input  N_REQ*W_LEN  signed operand A, requester i at slice i.
REQ-010 SHALL have port req_b  input  N_REQ*W_LEN  signed operand B, requester i at slice i.
REQ-011 SHALL have port rsp_valid  output  1  result valid.
REQ-012 SHALL have port rsp_ready  input  1  consumer accept.
REQ-013 SHALL have port rsp_id  output  clog2(N_REQ)  index of the originating requester.
REQ-014 SHALL have port rsp_product  output  W_LEN  signed Q(W_LEN-W_FRACT).W_FRACT product.
REQ-015 SHALL have port rsp_overflow  output  1  true product above max representable.
REQ-016 SHALL have port rsp_underflow  output  1  true product below min representable.

Function
REQ-017 SHALL grant round-robin: highest priority goes to the index one above the last accepted index, wrapping N_REQ-1 -> 0; after reset, index 0 has highest priority.
REQ-018 SHALL assert req_ready[i] only for the granted requester, and only when issue stage can accept (issue empty, or issue advancing this cycle).
REQ-019 SHALL treat a transfer as req_valid[i] & req_ready[i]; the priority pointer SHALL update only on a transfer, never on a grant alone.
REQ-020 SHALL require requesters to hold valid and operands stable until transfer; the grant may change while no transfer occurs.
REQ-021 SHALL be a 2-stage pipeline: issue register (operands, id) then result register (product, flags, id); accept at cycle t -> rsp_valid at t+2 absent backpressure.
REQ-022 SHALL sustain one transfer per cycle while rsp_ready is high.
REQ-023 SHALL stall both stages when rsp_valid & !rsp_ready; rsp_* SHALL hold stable while stalled; no result dropped or duplicated.
REQ-024 SHALL compute full 2*W_LEN-bit signed product P = a*b; raw result = P[W_LEN+W_FRACT-1:W_FRACT] (floor).
REQ-025 SHALL flag overflow when P[2*W_LEN-1:W_LEN+W_FRACT-1] are not all equal and P >= 0; underflow when not all equal and P < 0; never both.
REQ-026 SHALL output 2^(W_LEN-1)-1 on overflow and -2^(W_LEN-1) on underflow when SAT=1; raw result when SAT=0; flags identical for either SAT.
REQ-027 SHALL guarantee any continuously valid requester is accepted within N_REQ transfers.

Reset
REQ-028 SHALL on reset clear rsp_valid, rsp_product, rsp_id, rsp_overflow, rsp_underflow to 0, req_ready to 0, both stage valids to 0, pointer to 0.
REQ-029 SHALL discard in-flight operations on reset mid-operation; no rsp_valid for them after reset release.
REQ-030 SHALL assert no req_ready during the cycle reset is high.

Structure
REQ-031 SHALL place default W_LEN/W_FRACT/N_REQ constants, id-width helper and saturation limit constants in shared package fxp_pkg.
REQ-032 SHALL implement the round-robin grant logic (request vector + pointer -> one-hot grant) as sub-module rr_grant.

Verification
REQ-033 SHALL cover: defaults, req 0 a=0x4000 b=0x4000 -> rsp at t+2: product 0x4000, id 0, no flags.
REQ-034 SHALL cover: a=0x7FFF b=0x7FFF -> overflow=1, product 0x7FFF (SAT=1) / 0xFFFC (SAT=0).
REQ-035 SHALL cover: a=0x7FFF b=0x8000 -> underflow=1, product 0x8000 (SAT=1); a=0xC000 b=0x4000 -> 0xC000, no flags.
REQ-036 SHALL cover: all 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 one per cycle.
REQ-037 SHALL cover: rsp_ready low 5 cycles with requests pending -> exactly 2 in flight, rsp_* stable, req_ready=0 once both stages full, order preserved after release.
REQ-038 SHALL cover: reset pulsed with 2 ops in flight -> rsp_valid 0 after reset, next grant to index 0.
